lcd_timing_ctrl: RTL and testbench
==================================

# lcd_timing_ctrl

Parametrised RGB parallel-LCD timing controller. It replaces the fixed 1056×525 generator with programmable porch, sync and active timing, and adds a configurable read-ahead lead toward the frame-buffer FIFO. It also supports RGB565 or RGB888 input, built-in colour-bar and solid-fill modes, and underflow detection. It sits between the frame-buffer read FIFO and the LCD pins.

## Interface
- H_SYNC, default 10: HSYNC width, pixel clocks.
- H_BP, default 36: horizontal back porch.
- H_ACTIVE, default 640: active pixels per line. Must be a multiple of 8.
- H_FP, default 370: horizontal front porch.
- V_SYNC / V_BP / V_ACTIVE / V_FP, defaults 10 / 13 / 480 / 22: the same four quantities in lines.
- SYNC_POL, default 0: active level of HSYNC and VSYNC.
- READ_LEAD, default 4: cycles from the `lcd_read` rise to the `DE` rise. Range 1..H_SYNC+H_BP.
- DATA_W, default 16: input pixel format. 16 = RGB565, 24 = RGB888.
- BLANK_RGB, default 24'h000000: colour driven outside the active area.
- UF_COLOR, default 24'hFF00FF: colour substituted for a pixel that underflows.
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-low reset.
- lcd_readdata  in  DATA_W  pixel data from the FIFO.
- lcd_valid  in  1  `lcd_readdata` holds a real pixel.
- lcd_read  out  1  pixel request, one per active pixel.
- mode  in  2  display mode. 0 = stream, 1 = colour bars, 2 = solid fill, 3 = treated as 2.
- solid_rgb  in  24  fill colour used in mode 2.
- clr_status  in  1  pulse that clears `underflow`.
- R / G / B  out  8 each  pixel colour.
- HSYNC, VSYNC, DE  out  1 each  sync and data-enable outputs.
- LCD_CLK  out  1  equals `clk` while `reset` is high, else 0.
- frame_start  out  1  one-cycle pulse at the start of each frame.
- underflow  out  1  sticky underflow status.

## Operation
- Counters:
  - `h` runs 0..H_TOTAL-1, with H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP.
  - `v` advances when `h` wraps and runs 0..V_TOTAL-1.
  - Both wrap to 0.
- Windows:
  - HA = [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE).
  - VA = [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE).
  - Sync is active while h < H_SYNC (HSYNC) and v < V_SYNC (VSYNC).
- Mode latching:
  - `mode` is latched into `mode_q` only in the last cycle of a frame (h = H_TOTAL-1, v = V_TOTAL-1).
  - A mid-frame change has no effect until the next frame.
  - `mode_q` resets to 0.
- Stream mode (`mode_q` = 0):
  - `lcd_read` is high for h in HA shifted earlier by READ_LEAD, and v in VA.
  - Result: exactly H_ACTIVE requests per active line.
- Capture (stream mode):
  - On each edge that sets DE, RGB loads from `lcd_readdata`.
  - The FIFO must present data READ_LEAD-1 cycles after it first sees `lcd_read` high.
- Pixel mapping:
  - DATA_W=16: R = {d[15:11], d[15:13]}, G = {d[10:5], d[10:9]}, B = {d[4:0], d[4:2]}.
  - DATA_W=24: R = d[23:16], G = d[15:8], B = d[7:0].
- Underflow:
  - A capture with `lcd_valid` = 0 outputs UF_COLOR and sets `underflow`.
  - `underflow` is cleared only by `clr_status`. If a new underflow occurs in the same cycle, set wins.
- Colour bars (`mode_q` = 1): `lcd_read` stays 0. The active line is 8 bars, each H_ACTIVE/8 wide, in this order:
  - white FFFFFF
  - yellow FFFF00
  - cyan 00FFFF
  - green 00FF00
  - magenta FF00FF
  - red FF0000
  - blue 0000FF
  - black 000000
- Solid fill (`mode_q` = 2/3): `lcd_read` stays 0 and active pixels are `solid_rgb`, sampled at capture.
- Outside the active area, RGB = BLANK_RGB.

## Timing
- All outputs except LCD_CLK are registered.
- HSYNC, VSYNC, DE, RGB and frame_start show the counter decode with 1 cycle latency. `lcd_read` leads DE by exactly READ_LEAD cycles.
- `frame_start` is high in the same cycle that VSYNC first goes active.
- Reset:
  - HSYNC and VSYNC go to ~SYNC_POL; DE, `lcd_read`, `frame_start` and `underflow` go to 0.
  - RGB goes to BLANK_RGB; counters and `mode_q` go to 0.
  - Assertion takes effect asynchronously, mid-line included.
- After reset release:
  - The first edge registers the h=0, v=0 decode, so `frame_start`, HSYNC and VSYNC go active together.
  - A partial frame is never emitted.
- Per line: DE is high for H_ACTIVE consecutive cycles. Per frame: DE is high on V_ACTIVE lines.

## Test plan
- Default parameters, mode 0, `lcd_valid`=1, data 16'hF800 -> HSYNC low 10 of every 1056 cycles; VSYNC low 10 of 525 lines; DE 640 cycles × 480 lines; DE rises 4 cycles after `lcd_read`; pixel = FF/00/00.
- Mode 0→1 at line 100 -> stream continues to end of frame. Next frame: x=0 FFFFFF, x=80 FFFF00, x=639 000000; `lcd_read` = 0 all frame.
- `lcd_valid`=0 for pixel 5 of the first active line -> that pixel = FF00FF and `underflow`=1 through later frames. A `clr_status` pulse clears it; `clr_status` coinciding with a new underflow leaves it 1.
- `reset` low at h=300, v=50 -> outputs take reset values that cycle. After release, `frame_start` occurs one edge later and the h sequence restarts at 0.
- H_ACTIVE=8, H_SYNC=H_BP=H_FP=2, V=2/1/4/1, DATA_W=24, READ_LEAD=1, data 24'h123456 -> R=12, G=34, B=56 with DE coincident with a same-cycle read; wrap at h=13 and v=7.
- Mode 2, `solid_rgb`=24'h0A0B0C, BLANK_RGB=24'h111111 -> active pixels = 0A0B0C, blanking = 111111.

Source files
------------

// File: rtl/lcd_timing_ctrl.sv
// rtl/lcd_timing_ctrl.sv - programmable RGB parallel-LCD timing controller
module lcd_timing_ctrl #(
    parameter int          H_SYNC    = 10,
    parameter int          H_BP      = 36,
    parameter int          H_ACTIVE  = 640,
    parameter int          H_FP      = 370,
    parameter int          V_SYNC    = 10,
    parameter int          V_BP      = 13,
    parameter int          V_ACTIVE  = 480,
    parameter int          V_FP      = 22,
    parameter bit          SYNC_POL  = 1'b0,
    parameter int          READ_LEAD = 4,
    parameter int          DATA_W    = 16,
    parameter logic [23:0] BLANK_RGB = 24'h000000,
    parameter logic [23:0] UF_COLOR  = 24'hFF00FF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] lcd_readdata,
    input  logic              lcd_valid,
    output logic              lcd_read,
    input  logic [1:0]        mode,
    input  logic [23:0]       solid_rgb,
    input  logic              clr_status,
    output logic [7:0]        R,
    output logic [7:0]        G,
    output logic [7:0]        B,
    output logic              HSYNC,
    output logic              VSYNC,
    output logic              DE,
    output logic              LCD_CLK,
    output logic              frame_start,
    output logic              underflow
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int HL      = HW + 1;
    localparam int VW      = $clog2(V_TOTAL + 1);
    localparam int BAR_W   = H_ACTIVE / 8;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] HS_END   = HW'(H_SYNC);
    localparam logic [HW-1:0] HA_START = HW'(H_SYNC + H_BP);
    localparam logic [HW-1:0] HA_END   = HW'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [HL-1:0] HL_START = HL'(H_SYNC + H_BP);
    localparam logic [HL-1:0] HL_END   = HL'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [HL-1:0] LEAD     = HL'(READ_LEAD);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] VS_END   = VW'(V_SYNC);
    localparam logic [VW-1:0] VA_START = VW'(V_SYNC + V_BP);
    localparam logic [VW-1:0] VA_END   = VW'(V_SYNC + V_BP + V_ACTIVE);

    localparam logic [1:0] MODE_STREAM = 2'd0;
    localparam logic [1:0] MODE_BARS   = 2'd1;

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [1:0]    mode_q, mode_d;
    logic          hs_q, hs_d, vs_q, vs_d, de_q, de_d, rd_q, rd_d, fs_q, fs_d, uf_q, uf_d;
    logic [23:0]   rgb_q, rgb_d;

    logic          h_act, v_act, rd_win;
    logic [HL-1:0] h_lead;
    logic [HW-1:0] bar_x;
    logic [2:0]    bar_idx;
    logic [23:0]   bar_rgb;
    logic [23:0]   stream_rgb;

    generate
        if (DATA_W == 24) begin : g_rgb888
            assign stream_rgb = lcd_readdata[23:0];
        end else begin : g_rgb565
            // Replicate the MSBs into the low bits so full-scale 565 maps to FF.
            assign stream_rgb = {lcd_readdata[15:11], lcd_readdata[15:13],
                                 lcd_readdata[10:5],  lcd_readdata[10:9],
                                 lcd_readdata[4:0],   lcd_readdata[4:2]};
        end
    endgenerate

    assign h_act  = (h_q >= HA_START) && (h_q < HA_END);
    assign v_act  = (v_q >= VA_START) && (v_q < VA_END);
    assign h_lead = HL'(h_q) + LEAD;
    assign rd_win = (h_lead >= HL_START) && (h_lead < HL_END);
    assign bar_x  = h_q - HA_START;

    always_comb begin
        bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (bar_x >= HW'(k * BAR_W)) bar_idx = 3'(k);
        end
    end

    always_comb begin
        case (bar_idx)
            3'd0:    bar_rgb = 24'hFFFFFF;
            3'd1:    bar_rgb = 24'hFFFF00;
            3'd2:    bar_rgb = 24'h00FFFF;
            3'd3:    bar_rgb = 24'h00FF00;
            3'd4:    bar_rgb = 24'hFF00FF;
            3'd5:    bar_rgb = 24'hFF0000;
            3'd6:    bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
    end

    always_comb begin
        h_d    = h_q + HW'(1);
        v_d    = v_q;
        mode_d = mode_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
            // Mode only switches on the frame boundary so a frame is never mixed.
            if (v_q == V_LAST) mode_d = mode;
        end

        hs_d = (h_q < HS_END) ? SYNC_POL : ~SYNC_POL;
        vs_d = (v_q < VS_END) ? SYNC_POL : ~SYNC_POL;
        de_d = h_act && v_act;
        rd_d = rd_win && v_act && (mode_q == MODE_STREAM);
        fs_d = (h_q == '0) && (v_q == '0);

        rgb_d = BLANK_RGB;
        uf_d  = uf_q;
        if (clr_status) uf_d = 1'b0;
        if (de_d) begin
            if (mode_q == MODE_STREAM) begin
                if (lcd_valid) begin
                    rgb_d = stream_rgb;
                end else begin
                    rgb_d = UF_COLOR;
                    uf_d  = 1'b1;
                end
            end else if (mode_q == MODE_BARS) begin
                rgb_d = bar_rgb;
            end else begin
                rgb_d = solid_rgb;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_q    <= '0;
            v_q    <= '0;
            mode_q <= MODE_STREAM;
            hs_q   <= ~SYNC_POL;
            vs_q   <= ~SYNC_POL;
            de_q   <= 1'b0;
            rd_q   <= 1'b0;
            fs_q   <= 1'b0;
            uf_q   <= 1'b0;
            rgb_q  <= BLANK_RGB;
        end else begin
            h_q    <= h_d;
            v_q    <= v_d;
            mode_q <= mode_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            de_q   <= de_d;
            rd_q   <= rd_d;
            fs_q   <= fs_d;
            uf_q   <= uf_d;
            rgb_q  <= rgb_d;
        end
    end

    assign R           = rgb_q[23:16];
    assign G           = rgb_q[15:8];
    assign B           = rgb_q[7:0];
    assign HSYNC       = hs_q;
    assign VSYNC       = vs_q;
    assign DE          = de_q;
    assign lcd_read    = rd_q;
    assign frame_start = fs_q;
    assign underflow   = uf_q;
    assign LCD_CLK     = clk & reset;

endmodule

// File: tb/tb_lcd_timing_ctrl.sv
// tb/tb_lcd_timing_ctrl.sv - directed self-checking bench for lcd_timing_ctrl
`timescale 1ns/1ps
module tb_lcd_timing_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;

    logic [15:0] a_data = 16'hF800;
    logic        a_valid = 1'b1, a_clr = 1'b0;
    logic [1:0]  a_mode = 2'd0;
    logic [23:0] a_solid = 24'h0;
    logic        a_read, a_hs, a_vs, a_de, a_lclk, a_fs, a_uf;
    logic [7:0]  a_r, a_g, a_b;

    logic [23:0] b_data = 24'h123456;
    logic        b_valid = 1'b1, b_clr = 1'b0;
    logic [1:0]  b_mode = 2'd0;
    logic [23:0] b_solid = 24'h0;
    logic        b_read, b_hs, b_vs, b_de, b_lclk, b_fs, b_uf;
    logic [7:0]  b_r, b_g, b_b;

    always #5 clk = ~clk;

    // H total 22 (active h 4..19), V total 8 (active v 3..6), lead 3
    lcd_timing_ctrl #(
        .H_SYNC(2), .H_BP(2), .H_ACTIVE(16), .H_FP(2),
        .V_SYNC(2), .V_BP(1), .V_ACTIVE(4), .V_FP(1),
        .SYNC_POL(1'b0), .READ_LEAD(3), .DATA_W(16),
        .BLANK_RGB(24'h111111), .UF_COLOR(24'hFF00FF)
    ) u_dut16 (
        .clk(clk), .reset(reset), .lcd_readdata(a_data), .lcd_valid(a_valid),
        .lcd_read(a_read), .mode(a_mode), .solid_rgb(a_solid), .clr_status(a_clr),
        .R(a_r), .G(a_g), .B(a_b), .HSYNC(a_hs), .VSYNC(a_vs), .DE(a_de),
        .LCD_CLK(a_lclk), .frame_start(a_fs), .underflow(a_uf)
    );

    // H total 14 (active h 4..11), V total 8, lead 1
    lcd_timing_ctrl #(
        .H_SYNC(2), .H_BP(2), .H_ACTIVE(8), .H_FP(2),
        .V_SYNC(2), .V_BP(1), .V_ACTIVE(4), .V_FP(1),
        .SYNC_POL(1'b0), .READ_LEAD(1), .DATA_W(24)
    ) u_dut24 (
        .clk(clk), .reset(reset), .lcd_readdata(b_data), .lcd_valid(b_valid),
        .lcd_read(b_read), .mode(b_mode), .solid_rgb(b_solid), .clr_status(b_clr),
        .R(b_r), .G(b_g), .B(b_b), .HSYNC(b_hs), .VSYNC(b_vs), .DE(b_de),
        .LCD_CLK(b_lclk), .frame_start(b_fs), .underflow(b_uf)
    );

    task automatic step();
        @(negedge clk);
        cyc = cyc + 1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if ({a_hs, a_vs} !== 2'b11) begin fails++; $display("FAIL reset_sync got %b want 11", {a_hs, a_vs}); end
        tests++; if ({a_de, a_read, a_fs, a_uf} !== 4'b0) begin fails++; $display("FAIL reset_flags got %b want 0000", {a_de, a_read, a_fs, a_uf}); end
        tests++; if ({a_r, a_g, a_b} !== 24'h111111) begin fails++; $display("FAIL reset_rgb got %h want 111111", {a_r, a_g, a_b}); end
        tests++; if ({b_r, b_g, b_b} !== 24'h000000) begin fails++; $display("FAIL reset_rgb24 got %h want 000000", {b_r, b_g, b_b}); end
        @(posedge clk); #1;
        tests++; if (a_lclk !== 1'b0) begin fails++; $display("FAIL reset_lcdclk got %b want 0", a_lclk); end
        @(negedge clk);
    endtask

    task automatic test_frame_stream();
        int hs_lo = 0, vs_lo = 0, de_n = 0, rd_n = 0, fs_n = 0;
        int first_rd = 0, first_de = 0, run = 0, max_run = 0, rgb_bad = 0;
        reset = 1'b1;
        cyc = 0;
        for (int i = 0; i < 176; i++) begin
            step();
            if (cyc == 1) begin
                tests++; if ({a_fs, a_hs, a_vs} !== 3'b100) begin fails++; $display("FAIL first_edge fs/hs/vs got %b want 100", {a_fs, a_hs, a_vs}); end
            end
            if (!a_hs) hs_lo++;
            if (!a_vs) vs_lo++;
            if (a_fs) fs_n++;
            if (a_read) begin rd_n++; if (first_rd == 0) first_rd = cyc; end
            if (a_de) begin
                de_n++; run++;
                if (first_de == 0) first_de = cyc;
                if ({a_r, a_g, a_b} !== 24'hFF0000) rgb_bad++;
            end else begin
                run = 0;
            end
            if (run > max_run) max_run = run;
        end
        a_data = 16'hA5C3;
        tests++; if (hs_lo !== 16) begin fails++; $display("FAIL hsync_low got %0d want 16", hs_lo); end
        tests++; if (vs_lo !== 44) begin fails++; $display("FAIL vsync_low got %0d want 44", vs_lo); end
        tests++; if (de_n !== 64) begin fails++; $display("FAIL de_count got %0d want 64", de_n); end
        tests++; if (rd_n !== 64) begin fails++; $display("FAIL read_count got %0d want 64", rd_n); end
        tests++; if (fs_n !== 1) begin fails++; $display("FAIL fs_count got %0d want 1", fs_n); end
        tests++; if (first_rd !== 68) begin fails++; $display("FAIL first_read got %0d want 68", first_rd); end
        tests++; if (first_de !== 71) begin fails++; $display("FAIL first_de got %0d want 71", first_de); end
        tests++; if (max_run !== 16) begin fails++; $display("FAIL de_run got %0d want 16", max_run); end
        tests++; if (rgb_bad !== 0) begin fails++; $display("FAIL rgb565_red bad pixels %0d want 0", rgb_bad); end
    endtask

    task automatic test_underflow();
        int rd_n = 0;
        while (cyc < 352) begin
            step();
            if (a_read) rd_n++;
            if (cyc == 251) begin
                tests++; if (a_uf !== 1'b0) begin fails++; $display("FAIL uf_before got %b want 0", a_uf); end
                tests++; if ({a_r, a_g, a_b} !== 24'hA5BA18) begin fails++; $display("FAIL rgb565_map got %h want A5BA18", {a_r, a_g, a_b}); end
                a_valid = 1'b0;
            end else if (cyc == 252) begin
                tests++; if ({a_de, a_uf} !== 2'b11) begin fails++; $display("FAIL uf_set de/uf got %b want 11", {a_de, a_uf}); end
                tests++; if ({a_r, a_g, a_b} !== 24'hFF00FF) begin fails++; $display("FAIL uf_color got %h want FF00FF", {a_r, a_g, a_b}); end
                a_valid = 1'b1;
            end else if (cyc == 253) begin
                tests++; if (a_uf !== 1'b1) begin fails++; $display("FAIL uf_sticky got %b want 1", a_uf); end
            end else if (cyc == 254) begin
                a_clr = 1'b1;
            end else if (cyc == 255) begin
                tests++; if (a_uf !== 1'b0) begin fails++; $display("FAIL uf_clear got %b want 0", a_uf); end
                tests++; if ({a_r, a_g, a_b} !== 24'hA5BA18) begin fails++; $display("FAIL uf_recover got %h want A5BA18", {a_r, a_g, a_b}); end
                a_clr = 1'b0;
            end else if (cyc == 257) begin
                a_valid = 1'b0;
                a_clr   = 1'b1;
            end else if (cyc == 258) begin
                tests++; if (a_uf !== 1'b1) begin fails++; $display("FAIL uf_set_wins got %b want 1", a_uf); end
                a_valid = 1'b1;
                a_clr   = 1'b0;
            end else if (cyc == 286) begin
                a_mode = 2'd1;
            end
        end
        tests++; if (rd_n !== 64) begin fails++; $display("FAIL midframe_mode reads got %0d want 64", rd_n); end
    endtask

    task automatic test_color_bars();
        int rd_n = 0;
        while (cyc < 528) begin
            step();
            if (a_read) rd_n++;
            if (cyc == 423) begin
                tests++; if ({a_r, a_g, a_b} !== 24'hFFFFFF) begin fails++; $display("FAIL bar_x0 got %h want FFFFFF", {a_r, a_g, a_b}); end
            end else if (cyc == 425) begin
                tests++; if ({a_r, a_g, a_b} !== 24'hFFFF00) begin fails++; $display("FAIL bar_x2 got %h want FFFF00", {a_r, a_g, a_b}); end
            end else if (cyc == 431) begin
                tests++; if ({a_r, a_g, a_b} !== 24'hFF00FF) begin fails++; $display("FAIL bar_x8 got %h want FF00FF", {a_r, a_g, a_b}); end
            end else if (cyc == 438) begin
                tests++; if ({a_de, a_r, a_g, a_b} !== {1'b1, 24'h000000}) begin fails++; $display("FAIL bar_x15 got %b/%h want 1/000000", a_de, {a_r, a_g, a_b}); end
            end else if (cyc == 439) begin
                tests++; if ({a_de, a_r, a_g, a_b} !== {1'b0, 24'h111111}) begin fails++; $display("FAIL bar_blank got %b/%h want 0/111111", a_de, {a_r, a_g, a_b}); end
            end else if (cyc == 450) begin
                a_mode  = 2'd2;
                a_solid = 24'h0A0B0C;
            end else if (cyc == 500) begin
                tests++; if (a_uf !== 1'b1) begin fails++; $display("FAIL uf_later_frame got %b want 1", a_uf); end
            end
        end
        tests++; if (rd_n !== 0) begin fails++; $display("FAIL bars_reads got %0d want 0", rd_n); end
    endtask

    task automatic test_solid();
        int rd_n = 0;
        while (cyc < 704) begin
            step();
            if (a_read) rd_n++;
            if (cyc == 598) begin
                tests++; if ({a_de, a_r, a_g, a_b} !== {1'b0, 24'h111111}) begin fails++; $display("FAIL solid_blank got %b/%h want 0/111111", a_de, {a_r, a_g, a_b}); end
            end else if (cyc == 599 || cyc == 614) begin
                tests++; if ({a_de, a_r, a_g, a_b} !== {1'b1, 24'h0A0B0C}) begin fails++; $display("FAIL solid_px cyc %0d got %b/%h want 1/0A0B0C", cyc, a_de, {a_r, a_g, a_b}); end
            end else if (cyc == 650) begin
                a_mode = 2'd0;
            end
        end
        tests++; if (rd_n !== 0) begin fails++; $display("FAIL solid_reads got %0d want 0", rd_n); end
    endtask

    task automatic test_reset_midline();
        int first_de = 0;
        while (cyc < 781) step();
        tests++; if ({a_de, a_read, a_uf} !== 3'b111) begin fails++; $display("FAIL pre_reset de/rd/uf got %b want 111", {a_de, a_read, a_uf}); end
        reset = 1'b0;
        #1;
        tests++; if ({a_de, a_read, a_fs, a_uf, a_hs, a_vs} !== 6'b000011) begin fails++; $display("FAIL async_reset got %b want 000011", {a_de, a_read, a_fs, a_uf, a_hs, a_vs}); end
        tests++; if ({a_r, a_g, a_b} !== 24'h111111) begin fails++; $display("FAIL async_reset_rgb got %h want 111111", {a_r, a_g, a_b}); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cyc = 0;
        for (int i = 0; i < 80; i++) begin
            step();
            if (cyc == 1) begin
                tests++; if ({a_fs, a_hs, a_vs} !== 3'b100) begin fails++; $display("FAIL restart_edge fs/hs/vs got %b want 100", {a_fs, a_hs, a_vs}); end
            end
            if (a_de && first_de == 0) first_de = cyc;
        end
        tests++; if (first_de !== 71) begin fails++; $display("FAIL restart_first_de got %0d want 71", first_de); end
    endtask

    task automatic test_rgb888();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        cyc = 0;
        for (int i = 0; i < 113; i++) begin
            step();
            case (cyc)
                1: begin
                    tests++; if (b_fs !== 1'b1) begin fails++; $display("FAIL b_first_fs got %b want 1", b_fs); end
                end
                14: begin
                    tests++; if (b_hs !== 1'b1) begin fails++; $display("FAIL b_h13_hsync got %b want 1", b_hs); end
                end
                15: begin
                    tests++; if (b_hs !== 1'b0) begin fails++; $display("FAIL b_hwrap_hsync got %b want 0", b_hs); end
                end
                46: begin
                    tests++; if ({b_read, b_de} !== 2'b10) begin fails++; $display("FAIL b_read_lead rd/de got %b want 10", {b_read, b_de}); end
                end
                47: begin
                    tests++; if ({b_read, b_de} !== 2'b11) begin fails++; $display("FAIL b_de_rise rd/de got %b want 11", {b_read, b_de}); end
                    tests++; if ({b_r, b_g, b_b} !== 24'h123456) begin fails++; $display("FAIL b_rgb888 got %h want 123456", {b_r, b_g, b_b}); end
                end
                54: begin
                    tests++; if ({b_read, b_de} !== 2'b01) begin fails++; $display("FAIL b_last_px rd/de got %b want 01", {b_read, b_de}); end
                end
                55: begin
                    tests++; if ({b_de, b_r, b_g, b_b} !== {1'b0, 24'h000000}) begin fails++; $display("FAIL b_fp got %b/%h want 0/000000", b_de, {b_r, b_g, b_b}); end
                end
                112: begin
                    tests++; if ({b_vs, b_fs} !== 2'b10) begin fails++; $display("FAIL b_v7 vs/fs got %b want 10", {b_vs, b_fs}); end
                end
                113: begin
                    tests++; if ({b_vs, b_fs} !== 2'b01) begin fails++; $display("FAIL b_vwrap vs/fs got %b want 01", {b_vs, b_fs}); end
                end
                default: ;
            endcase
        end
    endtask

    initial begin
        test_reset();
        test_frame_stream();
        test_underflow();
        test_color_bars();
        test_solid();
        test_reset_midline();
        test_rgb888();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
